// File: rtl/dm_arb.sv
// Round-robin arbiter sharing the single-port data memory between the CPU MEM stage
// (requester 0) and a secondary master (requester 1), with bounded burst locking.
module dm_arb #(
  parameter int AW      = 7,
  parameter int DW      = 32,
  parameter int MAXLOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          stall0,
  output logic          stall1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd,
  output logic          dm_wr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  localparam logic [8:0] MAXLOCK_W = 9'(MAXLOCK);

  owner_e        owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic [8:0]    lock_inc;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Nine bits so MAXLOCK=255 cannot wrap the comparison.
  assign lock_inc = {1'b0, lock_cnt_q} + 9'd1;

  // An owner that drops its request loses the lock in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (owner_q == OWN_0 && req0) begin
      gnt0 = 1'b1;
    end else if (owner_q == OWN_1 && req1) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = ~prio_q;
      gnt1 = prio_q;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  assign stall0 = req0 & ~gnt0;
  assign stall1 = req1 & ~gnt1;

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    if (gnt0) begin
      dm_addr  = addr0;
      dm_wdata = wdata0;
      dm_wr    = wr0;
      dm_rd    = ~wr0;
    end else if (gnt1) begin
      dm_addr  = addr1;
      dm_wdata = wdata1;
      dm_wr    = wr1;
      dm_rd    = ~wr1;
    end
  end

  always_comb begin
    prio_d     = prio_q;
    owner_d    = OWN_NONE;
    lock_cnt_d = '0;
    rvalid0_d  = gnt0 & ~wr0;
    rvalid1_d  = gnt1 & ~wr1;
    rdata0_d   = rvalid0_d ? dm_rdata : rdata0_q;
    rdata1_d   = rvalid1_d ? dm_rdata : rdata1_q;
    if (gnt0) begin
      prio_d = 1'b1;
      if (lock0 && lock_inc < MAXLOCK_W) begin
        owner_d    = OWN_0;
        lock_cnt_d = lock_inc[7:0];
      end
    end else if (gnt1) begin
      prio_d = 1'b0;
      if (lock1 && lock_inc < MAXLOCK_W) begin
        owner_d    = OWN_1;
        lock_cnt_d = lock_inc[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= 1'b0;
      owner_q    <= OWN_NONE;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb: drives a 128x32 memory model and checks grants,
// stalls, memory drive and read-return against hand-computed values.
module tb_dm_arb;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, wr0, wr1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, stall0, stall1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] dm_addr;
  logic          dm_rd, dm_wr;
  logic [DW-1:0] dm_wdata, dm_rdata;

  logic [DW-1:0] mem [128];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  dm_arb #(.AW(AW), .DW(DW), .MAXLOCK(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  function automatic logic [DW-1:0] pat(input int a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction

  // Memory model: reloads a known pattern while reset is held.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= pat(i);
    end else if (dm_wr) begin
      mem[dm_addr] <= dm_wdata;
    end
  end
  assign dm_rdata = mem[dm_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Let combinational outputs settle and report the beat.
  task automatic settle();
    #4;
    $display("cycle %0d: req=%b%b gnt=%b%b addr=%0d rd=%b wr=%b wdata=%h rvalid=%b%b",
             cyc, req1, req0, gnt1, gnt0, dm_addr, dm_rd, dm_wr, dm_wdata, rvalid1, rvalid0);
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  logic gnt0_exp;

  initial begin
    idle();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    settle();
    // Reset state
    chk("rst_gnt",    {30'b0, gnt1, gnt0}, 0);
    chk("rst_rvalid", {30'b0, rvalid1, rvalid0}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_dm",     {23'b0, dm_rd, dm_wr, dm_addr}, 0);

    // 1: simultaneous reads, prio=0 favours requester 0
    tick();
    req0 = 1; addr0 = 5; req1 = 1; addr1 = 9;
    settle();
    chk("t1_gnt_c1", {30'b0, gnt1, gnt0}, 2'b01);
    chk("t1_stall1", {31'b0, stall1}, 1);
    chk("t1_dm_c1",  {24'b0, dm_rd, dm_addr}, {24'b0, 1'b1, 7'd5});
    tick();
    req0 = 0;
    settle();
    chk("t1_gnt_c2", {30'b0, gnt1, gnt0}, 2'b10);
    chk("t1_dmaddr", {25'b0, dm_addr}, 9);
    chk("t1_rv0",    {30'b0, rvalid1, rvalid0}, 2'b01);
    chk("t1_rd0",    rdata0, pat(5));
    tick();
    idle();
    settle();
    chk("t1_rv1",    {30'b0, rvalid1, rvalid0}, 2'b10);
    chk("t1_rd1",    rdata1, pat(9));

    // 2: continuous writes, no lock -> alternating grants
    tick();
    req0 = 1; wr0 = 1; addr0 = 20; wdata0 = 32'h11;
    req1 = 1; wr1 = 1; addr1 = 21; wdata1 = 32'h22;
    settle();
    chk("t2_gnt_b1",  {28'b0, stall1, stall0, gnt1, gnt0}, 4'b1001);
    chk("t2_wd_b1",   dm_wdata, 32'h11);
    tick();
    wdata0 = 32'h33;
    settle();
    chk("t2_gnt_b2",  {28'b0, stall1, stall0, gnt1, gnt0}, 4'b0110);
    chk("t2_wd_b2",   dm_wdata, 32'h22);
    tick();
    wdata1 = 32'h44;
    settle();
    chk("t2_gnt_b3",  {28'b0, stall1, stall0, gnt1, gnt0}, 4'b1001);
    chk("t2_wd_b3",   {dm_wr, dm_wdata[30:0]}, {1'b1, 31'h33});
    tick();
    req0 = 0; wr0 = 0;
    settle();
    chk("t2_gnt_b4",  {28'b0, stall1, stall0, gnt1, gnt0}, 4'b0010);
    chk("t2_wd_b4",   dm_wdata, 32'h44);
    tick();
    idle();
    req0 = 1; addr0 = 20;
    settle();
    chk("t2_rvalid_wr", {30'b0, rvalid1, rvalid0}, 0);
    tick();
    addr0 = 21;
    settle();
    chk("t2_mem20", rdata0, 32'h33);
    tick();
    idle();
    settle();
    chk("t2_mem21", rdata0, 32'h44);

    // 3: write by requester 1 then read by requester 0 sees the new data
    tick();
    req1 = 1; wr1 = 1; addr1 = 3; wdata1 = 32'hDEADBEEF;
    settle();
    chk("t3_gnt_w", {30'b0, gnt1, gnt0}, 2'b10);
    tick();
    idle();
    req0 = 1; addr0 = 3;
    settle();
    chk("t3_gnt_r", {30'b0, gnt1, gnt0}, 2'b01);
    chk("t3_norv1", {31'b0, rvalid1}, 0);
    tick();
    idle();
    settle();
    chk("t3_rv0",   {31'b0, rvalid0}, 1);
    chk("t3_rd0",   rdata0, 32'hDEADBEEF);

    // Single read by requester 1 returns prio to requester 0
    tick();
    req1 = 1; addr1 = 0;
    settle();
    chk("pre4_gnt", {30'b0, gnt1, gnt0}, 2'b10);

    // 4: locked burst by requester 0 is released after 8 beats
    for (int i = 0; i < 12; i++) begin
      tick();
      req0 = 1; wr0 = 1; lock0 = 1; addr0 = 40; wdata0 = 32'(i);
      req1 = 1; wr1 = 0; addr1 = 9;
      settle();
      gnt0_exp = (i != 8);
      chk($sformatf("t4_gnt_b%0d", i + 1), {30'b0, gnt1, gnt0}, gnt0_exp ? 2'b01 : 2'b10);
      if (i == 9) chk("t4_rd1", rdata1, pat(9));
    end
    tick();
    req0 = 0; wr0 = 0; lock0 = 0;
    settle();
    chk("t4_lapse", {30'b0, gnt1, gnt0}, 2'b10);

    // 5: locked burst by requester 1, dropped after 3 beats
    tick();
    idle();
    req1 = 1; wr1 = 1; lock1 = 1; addr1 = 50; wdata1 = 32'h50;
    settle();
    chk("t5_gnt_b1", {30'b0, gnt1, gnt0}, 2'b10);
    tick();
    req0 = 1; addr0 = 5;
    settle();
    chk("t5_gnt_b2", {29'b0, stall0, gnt1, gnt0}, 3'b110);
    tick();
    settle();
    chk("t5_gnt_b3", {29'b0, stall0, gnt1, gnt0}, 3'b110);
    chk("t5_cnt_b3", {24'b0, dut.lock_cnt_q}, 2);
    tick();
    req1 = 0; wr1 = 0; lock1 = 0;
    settle();
    chk("t5_gnt_b4", {30'b0, gnt1, gnt0}, 2'b01);
    tick();
    idle();
    settle();
    chk("t5_owner",  {30'b0, dut.owner_q}, 0);
    chk("t5_cnt",    {24'b0, dut.lock_cnt_q}, 0);
    chk("t5_rd0",    rdata0, pat(5));

    // 6: reset during a locked read burst
    tick();
    req0 = 1; lock0 = 1; addr0 = 7;
    settle();
    chk("t6_gnt_b1", {30'b0, gnt1, gnt0}, 2'b01);
    tick();
    addr0 = 8;
    reset = 1;
    settle();
    tick();
    reset = 0;
    idle();
    req0 = 1; addr0 = 10; req1 = 1; addr1 = 11;
    settle();
    chk("t6_rv",     {30'b0, rvalid1, rvalid0}, 0);
    chk("t6_rd0",    rdata0, 0);
    chk("t6_rd1",    rdata1, 0);
    chk("t6_owner",  {30'b0, dut.owner_q}, 0);
    chk("t6_gnt",    {30'b0, gnt1, gnt0}, 2'b01);
    tick();
    idle();
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arb.md
Name: dm_arb

Overview:
Two-requester arbiter that shares the single-port 128x32 data memory between the CPU MEM stage (requester 0) and a secondary master such as a debug/DMA port (requester 1). It grants one access per cycle, drives the data memory's address/rd/wr/wdata lines, and registers read data back to the requester that issued the read. Fairness is round-robin. A bounded lock lets one requester hold the memory for short bursts.

Parameters:
AW, 7, data memory address width
DW, 32, data width
MAXLOCK, 8, maximum consecutive locked beats before ownership is forcibly released (range 1..255)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req0 / req1  in  1  access request from requester 0 / 1
wr0 / wr1  in  1  1 = write, 0 = read (qualified by reqN)
addr0 / addr1  in  AW  access address
wdata0 / wdata1  in  DW  write data
lock0 / lock1  in  1  request to keep the grant next cycle (burst)
gnt0 / gnt1  out  1  combinational grant; access performed this cycle
stall0 / stall1  out  1  reqN & ~gntN
rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN holds the result of the read granted last cycle
rdata0 / rdata1  out  DW  registered read data, held until the next read by that requester
dm_addr  out  AW  to data memory
dm_rd, dm_wr  out  1  to data memory
dm_wdata  out  DW  to data memory
dm_rdata  in  DW  from data memory (combinational read, write-bypass included)

Behaviour:
- State: prio (1 bit, requester favoured on a tie), owner (NONE/0/1), lock_cnt (8 bits), rdata0/1, rvalid0/1.
- Reset values: prio=0, owner=NONE, lock_cnt=0, rvalidN=0, rdataN=0. Grants are combinational, so all dm_* outputs are 0 while reqN=0.
- Grant (combinational, at most one grant per cycle):
  - If owner==i and req_i: grant i, whatever the other requester does.
  - If owner==i and !req_i: the lock lapses and normal arbitration applies in the same cycle.
  - Normal arbitration: a single requester is granted; if both request, grant requester prio.
- Memory drive: granted i -> dm_addr=addr_i, dm_wdata=wdata_i, dm_wr=wr_i, dm_rd=~wr_i. No grant -> dm_addr=0, dm_wdata=0, dm_rd=dm_wr=0.
- Per granted beat to i, at the clock edge:
  - prio <= ~i.
  - If lock_i and lock_cnt+1 < MAXLOCK: owner<=i, lock_cnt<=lock_cnt+1.
  - Else: owner<=NONE, lock_cnt<=0.
- Cycle with no grant: owner<=NONE, lock_cnt<=0, prio unchanged.
- Read latency: read granted in cycle T -> rdata_i <= dm_rdata at the end of T, rvalid_i=1 during T+1 only. Writes produce no rvalid.
- A requester holds req/wr/addr/wdata stable until it sees gnt. A granted request is consumed that cycle. If req stays high the next cycle, that is a new request.
- Write in T by one requester followed by a read of the same address in T+1 by either requester returns the new data.
- MAXLOCK=1: lock has no effect (strict round-robin).
- Forced release: after MAXLOCK locked beats, ownership drops and prio favours the other requester, so a waiting requester is granted within MAXLOCK+1 cycles.
- Reset asserted mid-burst: ownership dropped, pending rvalid cleared, rdata zeroed, in the same edge.
- The arbiter itself never stalls the memory. Either requester's stall is the only back-pressure.

Test Plan:
1. After reset: req0=1 rd addr=5 and req1=1 rd addr=9 simultaneously -> gnt0 first (prio=0), gnt1 next cycle. Then rvalid0 with mem[5], followed by rvalid1 with mem[9].
2. Both requesting writes continuously, no lock -> grants alternate 0,1,0,1. stall is high on the non-granted side each cycle. mem contents match the last write per address.
3. req1 writes 0xDEADBEEF to addr 3 in cycle T, req0 reads addr 3 in T+1 -> rvalid0 in T+2 with rdata0=0xDEADBEEF.
4. MAXLOCK=8, req0 with lock0=1 held for 12 cycles, req1 high throughout -> gnt0 for 8 cycles, gnt1 on cycle 9, then gnt0 resumes.
5. Locked burst by requester 1, req1 dropped after 3 beats while req0 pending -> gnt0 the very next cycle. owner=NONE, lock_cnt=0.
6. reset pulsed during a locked read burst, with rvalid due next cycle -> rvalid stays 0, rdata=0, next contention grants requester 0 first.
